// File: rtl/mem_issue_buffer.sv
// mem_issue_buffer: in-order request buffer between the load/store queue and
// the data cache.
//
// Requests from the LSQ are queued in a DEPTH-entry FIFO and issued to the
// cache one per cycle while the cache is not stalling and fewer than
// MAX_OUTSTANDING requests are awaiting a response. The LSQ is held off with
// stall_out when the FIFO is full; a request presented while full is dropped
// and flagged on the sticky overflow output.
//
// Optional feature: define MEM_ISSUE_BYPASS_EN to let a request arriving at
// an empty buffer go straight to the cache outputs on the same edge.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   addr_in/data_in/rw_in/id_in, valid_in   request from the LSQ
//   stall_out                buffer full, LSQ must hold its request
//   addr_out/data_out/rw_out/id_out, valid_out  registered issue to the cache
//   stall_in                 cache cannot accept requests
//   ready_in                 cache returned one response this cycle
//   outstanding              issued-but-unanswered request count
//   overflow                 sticky: request dropped while full
//   underflow                sticky: response seen with nothing outstanding
module mem_issue_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ID_W            = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rw_in,
  input  logic [ID_W-1:0]   id_in,
  input  logic              valid_in,
  output logic              stall_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              rw_out,
  output logic [ID_W-1:0]   id_out,
  output logic              valid_out,
  input  logic              stall_in,
  input  logic              ready_in,
  output logic [3:0]        outstanding,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W + 1 + ID_W;

  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
  localparam logic [3:0]      MaxOut    = 4'(MAX_OUTSTANDING);

  // Occupancy view of the FIFO, kept for assertions and debug visibility.
  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      outstanding_q, outstanding_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            valid_q;
  logic [EntW-1:0] payload_q;
  state_e          state_q, state_d;

  logic            can_issue, fire, bypass, issue, push;
  logic [EntW-1:0] in_entry, head_entry;

  assign in_entry   = {addr_in, data_in, rw_in, id_in};
  assign head_entry = mem_q[rd_ptr_q];

  assign can_issue = !stall_in && (outstanding_q < MaxOut);
  assign fire      = (count_q != '0) && can_issue;

`ifdef MEM_ISSUE_BYPASS_EN
  // An empty buffer hands the incoming request straight to the cache.
  assign bypass = (count_q == '0) && valid_in && can_issue;
`else
  assign bypass = 1'b0;
`endif

  assign issue = fire | bypass;
  // Fullness is judged on the pre-edge count; a same-cycle pop does not help.
  assign push  = valid_in && (count_q != CountFull) && !bypass;

  assign stall_out = (count_q == CountFull);

  always_comb begin
    count_d    = count_q + CntW'(push) - CntW'(fire);
    overflow_d = overflow_q | (valid_in && (count_q == CountFull));
  end

  always_comb begin
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (ready_in && (outstanding_q == '0) && !issue) begin
      underflow_d = 1'b1;
    end else begin
      outstanding_d = outstanding_q + 4'(issue) - 4'(ready_in);
    end
  end

  always_comb begin
    state_d = StPartial;
    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == CountFull) begin
      state_d = StFull;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      valid_q       <= 1'b0;
      payload_q     <= '0;
      state_q       <= StEmpty;
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      valid_q       <= issue;
      state_q       <= state_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (fire) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (issue) begin
        payload_q <= bypass ? in_entry : head_entry;
      end
    end
  end

  // Storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign {addr_out, data_out, rw_out, id_out} = payload_q;
  assign valid_out   = valid_q;
  assign outstanding = outstanding_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  always_comb begin
    if (!rst) begin
      assert ((state_q == StEmpty) == (count_q == '0));
      assert ((state_q == StFull) == (count_q == CountFull));
    end
  end

endmodule

// File: tb/tb_mem_issue_buffer.sv
module tb_mem_issue_buffer;

  localparam int Depth  = 4;
  localparam int MaxOut = 8;
`ifdef MEM_ISSUE_BYPASS_EN
  localparam int Lat = 0;
`else
  localparam int Lat = 1;
`endif

  logic        clk, rst;
  logic [31:0] addr_in, data_in, addr_out, data_out;
  logic        rw_in, valid_in, stall_out, rw_out, valid_out, stall_in, ready_in;
  logic [3:0]  id_in, id_out, outstanding;
  logic        overflow, underflow;

  mem_issue_buffer #(
    .DEPTH(Depth), .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_in(addr_in), .data_in(data_in), .rw_in(rw_in), .id_in(id_in),
    .valid_in(valid_in), .stall_out(stall_out),
    .addr_out(addr_out), .data_out(data_out), .rw_out(rw_out), .id_out(id_out),
    .valid_out(valid_out), .stall_in(stall_in), .ready_in(ready_in),
    .outstanding(outstanding), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        rw;
    logic [3:0]  id;
  } req_t;

  // Reference model: a plain queue of pending requests plus counters.
  req_t mq[$];
  int   m_out;
  bit   m_ovf, m_unf, m_valid;
  req_t m_pay;
  bit   model_en;

  int checks = 0;
  int errors = 0;
  logic [3:0] obs[$];
  int first_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out   = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_valid = 0;
    m_pay   = '{a: 32'h0, d: 32'h0, rw: 1'b0, id: 4'h0};
  endtask

  // Model step on every edge from the pre-edge inputs, then compare all outputs.
  always @(posedge clk) begin : model_proc
    int   cnt;
    bit   byp, fire, iss;
    req_t inp;
    if (model_en && !rst) begin
      cnt = mq.size();
      inp = '{a: addr_in, d: data_in, rw: rw_in, id: id_in};
`ifdef MEM_ISSUE_BYPASS_EN
      byp = (cnt == 0) && valid_in && !stall_in && (m_out < MaxOut);
`else
      byp = 0;
`endif
      fire = (cnt > 0) && !stall_in && (m_out < MaxOut);
      iss  = fire || byp;
      m_valid = iss;
      if (fire) m_pay = mq.pop_front();
      else if (byp) m_pay = inp;
      if (valid_in && !byp) begin
        if (cnt < Depth) mq.push_back(inp);
        else m_ovf = 1;
      end
      if (ready_in && m_out == 0 && !iss) m_unf = 1;
      else m_out = m_out + int'(iss) - int'(ready_in);
      #1;
      chk("valid_out", valid_out, m_valid);
      chk("addr_out", addr_out, m_pay.a);
      chk("data_out", data_out, m_pay.d);
      chk("rw_out", rw_out, m_pay.rw);
      chk("id_out", id_out, m_pay.id);
      chk("outstanding", outstanding, m_out);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
      chk("stall_out", stall_out, mq.size() == Depth);
    end
  end

  // Drive one cycle of inputs at the negedge; return just after the edge is checked.
  task automatic tick(input bit v, input int id, input bit si, input bit rdy);
    @(negedge clk);
    valid_in = v;
    id_in    = 4'(id);
    addr_in  = 32'(id) << 4;
    data_in  = 32'hD000_0000 | 32'(id);
    rw_in    = ~id_in[0];
    stall_in = si;
    ready_in = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic tick_obs(input bit v, input int id, input bit si, input bit rdy);
    tick(v, id, si, rdy);
    if (valid_out) obs.push_back(id_out);
  endtask

  task automatic tick_rand();
    @(negedge clk);
    valid_in = ($urandom_range(0, 9) < 7);
    addr_in  = $urandom;
    data_in  = $urandom;
    rw_in    = 1'($urandom);
    id_in    = 4'($urandom);
    stall_in = ($urandom_range(0, 9) < 3);
    ready_in = ($urandom_range(0, 9) < 4);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    model_en = 1'b0;
    valid_in = 0; addr_in = 0; data_in = 0; rw_in = 0; id_in = 0;
    stall_in = 0; ready_in = 0;
    model_reset();
    #12;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_stall_out", stall_out, 0);
    chk("rst_addr_out", addr_out, 0);
    chk("rst_id_out", id_out, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;

    // Reset in the middle of a stalled burst.
    tick(1, 1, 0, 0);
    for (int i = 2; i <= 5; i++) tick(1, i, 1, 0);
    chk("pre_rst_stall_out", stall_out, 1);
    chk("pre_rst_outstanding", outstanding, 1 - Lat);
    model_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_stall_out", stall_out, 0);
    chk("async_rst_valid_out", valid_out, 0);
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_id_out", id_out, 0);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 0;
    model_reset();
    model_en = 1'b1;
    obs.delete();
    tick_obs(1, 5, 0, 0);
    tick_obs(0, 0, 0, 0);
    tick_obs(0, 0, 0, 0);
    chk("post_rst_issues", obs.size(), 1);
    if (obs.size() > 0) chk("post_rst_id", obs[0], 5);
    tick(0, 0, 0, 1);

    // Basic in-order issue.
    obs.delete();
    first_idx = -1;
    for (int i = 0; i < 6; i++) begin
      tick_obs(i < 3, i + 1, 0, 0);
      if (valid_out && first_idx < 0) first_idx = i;
    end
    chk("basic_first_issue", first_idx, Lat);
    chk("basic_count", obs.size(), 3);
    for (int i = 0; i < obs.size() && i < 3; i++) chk("basic_id", obs[i], i + 1);
    chk("basic_outstanding", outstanding, 3);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    chk("basic_drained", outstanding, 0);

    // Fill while the cache stalls, overflow on the fifth push.
    for (int i = 1; i <= 5; i++) begin
      tick(1, i, 1, 0);
      if (i == 3) chk("fill3_stall_out", stall_out, 0);
      if (i == 4) chk("fill4_stall_out", stall_out, 1);
    end
    chk("full_overflow", overflow, 1);
    obs.delete();
    for (int i = 0; i < 6; i++) tick_obs(0, 0, 0, 0);
    chk("full_issue_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) chk("full_id", obs[i], i + 1);
    chk("full_stall_released", stall_out, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);

    // Underflow on a response with nothing outstanding.
    chk("pre_underflow", underflow, 0);
    tick(0, 0, 0, 1);
    chk("underflow_set", underflow, 1);
    chk("underflow_outstanding", outstanding, 0);

    // Issue latency into an empty buffer.
    tick(1, 7, 0, 0);
    chk("lat_valid_edge0", valid_out, Lat == 0);
    tick(0, 0, 0, 0);
    chk("lat_valid_edge1", valid_out, Lat == 1);
    chk("lat_id", id_out, 7);
    tick(0, 0, 0, 1);

    // Outstanding limit.
    for (int i = 0; i < 12; i++) tick(1, i, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("limit_outstanding", outstanding, MaxOut);
    chk("limit_stall_out", stall_out, 1);
    obs.delete();
    tick_obs(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick_obs(0, 0, 0, 0);
    chk("limit_one_more", obs.size(), 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 1);
    chk("limit_drained", outstanding, 0);

    // Steady push+fire at count 2, wrapping both pointers.
    tick(1, 0, 1, 0);
    tick(1, 1, 1, 0);
    obs.delete();
    for (int i = 2; i < 12; i++) tick_obs(1, i, 0, 1);
    for (int i = 0; i < 4; i++) tick_obs(0, 0, 0, 1);
    chk("wrap_count", obs.size(), 12);
    for (int i = 0; i < obs.size() && i < 12; i++) chk("wrap_id", obs[i], i);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) tick_rand();

    model_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_issue_buffer.md
Name: mem_issue_buffer

Overview:
- Request buffer between the load/store queue and the data cache.
- Accepts LSQ memory requests (addr, data, rw, ldst id), holds them in an in-order FIFO, and issues them to the cache only when the cache is not stalling and the outstanding-request limit is not reached.
- Counts outstanding requests using the cache's ready/response strobe.
- Raises stall back to the LSQ when full, so bursts and cache stalls no longer drop requests.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
ADDR_W, 32, address width
DATA_W, 32, store-data width
ID_W, 4, ldst queue id width
MAX_OUTSTANDING, 8, max issued-but-unanswered requests (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
addr_in  in  ADDR_W  request address from LSQ
data_in  in  DATA_W  store data from LSQ
rw_in  in  1  1=store, 0=load
id_in  in  ID_W  ldst queue id
valid_in  in  1  request present this cycle
stall_out  out  1  buffer full; LSQ must hold its request
addr_out  out  ADDR_W  address to cache
data_out  out  DATA_W  store data to cache
rw_out  out  1  rw to cache
id_out  out  ID_W  id to cache
valid_out  out  1  issue strobe to cache, one cycle per request
stall_in  in  1  cache cannot accept requests
ready_in  in  1  cache returned one response this cycle
outstanding  out  4  current issued-unanswered count
overflow  out  1  sticky: request dropped while full
underflow  out  1  sticky: ready_in seen with outstanding==0

Behaviour:
- Reset, asynchronous, any time including mid-burst:
  - FIFO count, read pointer and write pointer go to 0.
  - valid_out, outstanding, overflow and underflow go to 0.
  - addr_out, data_out, rw_out and id_out go to 0.
  - stall_out goes to 0.
  - Queued entries are discarded.
- stall_out is combinational: stall_out = (count == DEPTH).
- Push:
  - Occurs at the rising edge when valid_in=1 and count<DEPTH.
  - The entry is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Push while full:
  - Occurs when valid_in=1 and count==DEPTH.
  - The request is dropped and overflow is set (sticky until reset).
  - A pop in the same cycle does not free the slot for that push; fullness is judged on the pre-edge count.
- Issue condition (evaluated pre-edge): fire = (count>0) && !stall_in && (outstanding < MAX_OUTSTANDING).
- On fire:
  - At the edge, the head entry is registered onto addr_out/data_out/rw_out/id_out.
  - valid_out<=1.
  - rd_ptr advances with wrap.
  - count decrements.
- When not firing:
  - valid_out<=0.
  - The payload outputs hold their last value.
- Issue rate: at most one per cycle, strictly in FIFO order.
- Latency: a request pushed at edge N is visible on valid_out after edge N+1 at the earliest.
- Simultaneous push and fire: count is unchanged; both pointers advance.
- Outstanding counter:
  - +1 on fire, -1 on ready_in.
  - Both in the same cycle: unchanged.
  - ready_in with outstanding==0 and no fire: counter stays 0 and underflow is set (sticky).
  - ready_in with outstanding==0 and fire in the same cycle: counter becomes 0 (net 0).
- stall_in: blocks issue only; pushes continue until full.
- ready_in: never gated by stall_in.
- FSM, derived from count, used for assertions and debug:
  - EMPTY (count==0)
  - PARTIAL
  - FULL (count==DEPTH)
  - Transitions follow push/fire only.

Optional Feature:
Macro MEM_ISSUE_BYPASS_EN.
- Defined:
  - When count==0, valid_in=1, stall_in=0 and outstanding<MAX_OUTSTANDING, the incoming request is registered directly onto the outputs at edge N.
  - valid_out is seen after edge N, zero buffering latency.
  - The FIFO is not written; count stays 0.
  - Bypass counts as a fire for outstanding.
- Undefined:
  - All requests pass through the FIFO; minimum latency is one extra cycle.

Test Plan:
- Reset mid-operation: push 3 requests, stall_in=1, assert rst asynchronously between edges -> immediately count=0, stall_out=0, valid_out=0, outstanding=0; subsequent push of id=5 issues normally.
- Basic order: push ids 1,2,3 (addr 0x10,0x20,0x30, rw 0,1,0) with stall_in=0 -> valid_out high on 3 consecutive cycles starting one cycle after first push, id_out 1,2,3 in order; outstanding reaches 3; three ready_in pulses -> outstanding=0.
- Full/overflow: stall_in=1, push 5 requests with DEPTH=4 -> stall_out=1 after 4th push, 5th dropped, overflow=1; release stall_in -> exactly 4 issues, ids in push order, then stall_out=0.
- Outstanding limit: MAX_OUTSTANDING=2, push 4, no ready_in -> only 2 issues, count stays 2; one ready_in -> exactly one more issue next cycle.
- Simultaneous push+fire with wrap: keep FIFO at count=2 while pushing and firing every cycle for 10 cycles -> count constant 2, pointers wrap, id sequence preserved.
- Underflow and bypass: ready_in with outstanding=0 -> underflow=1, outstanding=0. With MEM_ISSUE_BYPASS_EN, push id=7 into empty buffer -> valid_out=1, id_out=7 after the same edge; without the macro -> one edge later.
